dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arbiter_rr_arbiter2.sv | 20 ++
 rtl/dmem_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port encrypted data-memory arbiter:
// FSM state encoding, default timing parameters and a counter-width helper.
package dmem_arb_pkg;

    // Default number of WAIT cycles before a transaction is aborted.
    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    // Default quiet period after reset. It must exceed the worst-case DMEM
    // latency (12 cycles) so that a done pulse from an abandoned operation
    // lands while the arbiter is still ignoring mem_done.
    localparam int DRAIN_CYCLES_DEFAULT = 24;

    typedef enum logic [2:0] {
        ST_DRAIN = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Width of a counter that has to reach (max(a, b) - 1).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant logic. A lone requester always wins;
// on a tie the port that was not granted last wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; last = 1 means port 1 was served most recently.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single encrypting DMEM. One transaction is
// in flight at a time: IDLE grants, ISSUE pulses the DMEM enable, WAIT waits
// for mem_done (or times out), RESP pulses the requester's ack. After reset
// the DRAIN state swallows any done pulse left over from an abandoned op,
// since the DMEM itself is not reset.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0,
    input  logic         we0,
    input  logic [31:0]  addr0,
    input  logic [127:0] wdata0,
    output logic [127:0] rdata0,
    output logic         ack0,
    output logic         err0,

    input  logic         req1,
    input  logic         we1,
    input  logic [31:0]  addr1,
    input  logic [127:0] wdata1,
    output logic [127:0] rdata1,
    output logic         ack1,
    output logic         err1,

    output logic         mem_read_enable,
    output logic         mem_write_enable,
    output logic [31:0]  mem_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    input  logic         mem_done,

    output logic         busy
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES, DRAIN_CYCLES);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST   = CW'(DRAIN_CYCLES - 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           last_grant;
    logic           cur_port;
    logic           cur_we;

    logic [1:0]     grant;
    logic           sel_port;
    logic           sel_we;
    logic [31:0]    sel_addr;
    logic [127:0]   sel_wdata;

    rr_arbiter2 u_rr (
        .req   ({req1, req0}),
        .last  (last_grant),
        .grant (grant)
    );

    // Route the winning port's request fields toward the latch in IDLE.
    always_comb begin
        sel_port  = grant[1];
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (sel_port) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Transaction FSM; every output is registered and set on the transition
    // into the state in which it must be visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_DRAIN;
            cnt              <= '0;
            last_grant       <= 1'b1;
            cur_port         <= 1'b0;
            cur_we           <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            rdata0           <= '0;
            rdata1           <= '0;
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            err0             <= 1'b0;
            err1             <= 1'b0;
            busy             <= 1'b1;
        end else begin
            ack0             <= 1'b0;
            ack1             <= 1'b0;
            err0             <= 1'b0;
            err1             <= 1'b0;
            mem_read_enable  <= 1'b0;
            mem_write_enable <= 1'b0;

            case (state)
                ST_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        cur_port         <= sel_port;
                        cur_we           <= sel_we;
                        mem_address      <= sel_addr;
                        mem_write_data   <= sel_wdata;
                        mem_write_enable <= sel_we;
                        mem_read_enable  <= ~sel_we;
                        state            <= ST_ISSUE;
                        busy             <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end

                ST_WAIT: begin
                    if (mem_done) begin
                        state <= ST_RESP;
                        cnt   <= '0;
                        if (cur_port) begin
                            ack1 <= 1'b1;
                            if (!cur_we) begin
                                rdata1 <= mem_read_data;
                            end
                        end else begin
                            ack0 <= 1'b1;
                            if (!cur_we) begin
                                rdata0 <= mem_read_data;
                            end
                        end
                    end else if (cnt == TIMEOUT_LAST) begin
                        state <= ST_RESP;
                        cnt   <= '0;
                        if (cur_port) begin
                            ack1 <= 1'b1;
                            err1 <= 1'b1;
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    last_grant <= cur_port;
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                end

                default: begin
                    state <= ST_DRAIN;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
